// File: rtl/clock_mode_ctrl.sv
// Alarm-clock style time keeper: debounced MODE/INC buttons drive a RUN/SET_HR/SET_MIN/SET_SEC FSM.
// Defining CLOCK_12H_EN switches the hour counter to 1..12 with an AM/PM flag.
module clock_mode_ctrl #(
    parameter int DEBOUNCE_N = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic       pm,
    output logic [1:0] state,
    output logic       day_carry
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        SET_SEC = 2'b11
    } state_t;

    localparam logic [3:0] DB_N = 4'(DEBOUNCE_N);

    state_t     cur;
    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] level;
    logic [1:0] level_q;
    logic [1:0] press;
    logic [3:0] db_cnt [2];
    logic       mode_ev;
    logic       inc_ev;
    logic [4:0] hr_next;
    logic       hr_wrap;

    assign raw     = {inc_btn, mode_btn};
    assign press   = level & ~level_q;
    assign mode_ev = press[0];
    assign inc_ev  = press[1] & ~press[0];
    assign state   = cur;

    // Bit 0 is MODE, bit 1 is INC; level rises after DB_N high samples and drops on any low sample.
    always_ff @(posedge clk) begin
        if (!clear) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            for (int i = 0; i < 2; i++) begin
                if (!sync2[i]) begin
                    db_cnt[i] <= '0;
                    level[i]  <= 1'b0;
                end else if (db_cnt[i] != DB_N) begin
                    db_cnt[i] <= db_cnt[i] + 4'd1;
                    if (db_cnt[i] == DB_N - 4'd1) begin
                        level[i] <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef CLOCK_12H_EN
    localparam logic [4:0] HR_RESET = 5'd12;
    logic pm_next;

    // 11->12 flips AM/PM; only 11 PM -> 12 AM counts as a new day.
    always_comb begin
        hr_next = hr + 5'd1;
        pm_next = pm;
        hr_wrap = 1'b0;
        if (hr == 5'd11) begin
            hr_next = 5'd12;
            pm_next = ~pm;
            hr_wrap = pm;
        end else if (hr == 5'd12) begin
            hr_next = 5'd1;
        end
    end
`else
    localparam logic [4:0] HR_RESET = 5'd0;

    always_comb begin
        hr_wrap = (hr == 5'd23);
        hr_next = hr_wrap ? 5'd0 : hr + 5'd1;
    end

    assign pm = 1'b0;
`endif

    // A MODE press always wins; a simultaneous INC press is dropped via inc_ev.
    always_ff @(posedge clk) begin
        if (!clear) begin
            cur       <= RUN;
            sec       <= '0;
            min       <= '0;
            hr        <= HR_RESET;
            day_carry <= 1'b0;
`ifdef CLOCK_12H_EN
            pm        <= 1'b0;
`endif
        end else begin
            day_carry <= 1'b0;
            if (mode_ev) begin
                cur <= state_t'(cur + 2'd1);
            end
            case (cur)
                RUN: begin
                    if (tick) begin
                        if (sec == 6'd59) begin
                            sec <= '0;
                            if (min == 6'd59) begin
                                min       <= '0;
                                hr        <= hr_next;
                                day_carry <= hr_wrap;
`ifdef CLOCK_12H_EN
                                pm        <= pm_next;
`endif
                            end else begin
                                min <= min + 6'd1;
                            end
                        end else begin
                            sec <= sec + 6'd1;
                        end
                    end
                end
                SET_HR: begin
                    if (inc_ev) begin
                        hr <= hr_next;
`ifdef CLOCK_12H_EN
                        pm <= pm_next;
`endif
                    end
                end
                SET_MIN: begin
                    if (inc_ev) begin
                        min <= (min == 6'd59) ? 6'd0 : min + 6'd1;
                    end
                end
                SET_SEC: begin
                    if (inc_ev) begin
                        sec <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
